// File: rtl/request_encoder_pkg.sv
// Shared constants and types for the request encoder and its picker.
package request_encoder_pkg;

   localparam int unsigned IDX_W = 2;
   localparam int unsigned REQ_N = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // One-hot mask for a request index
   function automatic logic [REQ_N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [REQ_N-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating first-set search over four request bits, starting at 'start'.
module rr_pick4
   import request_encoder_pkg::*;
(
   input  logic [REQ_N-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Walk offsets from farthest to nearest so the nearest set bit wins
   always_comb begin
      logic [IDX_W-1:0] pos;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = REQ_N - 1; k >= 0; k--) begin
         pos = start + IDX_W'(k);
         if (req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/request_encoder.sv
// Latches request pulses and presents one pending index at a time as a
// registered {address1,address0}/enable bundle, held until ready.
module request_encoder
   import request_encoder_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   input  logic ready,
   output logic address0,
   output logic address1,
   output logic enable,
   output logic busy
);

   logic [REQ_N-1:0] pending_q;
   logic [IDX_W-1:0] pointer_q;
   state_e           state_q;

   logic [REQ_N-1:0] req_in;
   logic [REQ_N-1:0] clr;
   logic [REQ_N-1:0] pending_d;
   logic [IDX_W-1:0] cur_idx;
   logic [IDX_W-1:0] next_ptr;
   logic [REQ_N-1:0] pick_req;
   logic [IDX_W-1:0] pick_start;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             accept;

   // Pending update, accept clear and picker inputs for the current state
   always_comb begin
      req_in    = {in3, in2, in1, in0};
      cur_idx   = {address1, address0};
      accept    = enable & ready;
      clr       = accept ? idx_onehot(cur_idx) : '0;
      // New pulses OR in after the clear, so a same-edge set survives
      pending_d = (pending_q & ~clr) | req_in;
      next_ptr  = ROUND_ROBIN ? IDX_W'(cur_idx + 1'b1) : '0;
      if (state_q == ST_HOLD) begin
         pick_req   = pending_q & ~clr;
         pick_start = next_ptr;
      end else begin
         pick_req   = pending_q;
         pick_start = pointer_q;
      end
   end

   rr_pick4 u_pick (
      .req   (pick_req),
      .start (pick_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Grant FSM: IDLE loads the first pick, HOLD waits for ready then chains or retires
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         pointer_q <= '0;
         state_q   <= ST_IDLE;
         address0  <= 1'b0;
         address1  <= 1'b0;
         enable    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  {address1, address0} <= pick_idx;
                  enable               <= 1'b1;
                  state_q              <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ready) begin
                  pointer_q <= next_ptr;
                  if (pick_found) begin
                     {address1, address0} <= pick_idx;
                  end else begin
                     // Address registers keep the last granted index
                     enable  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Activity flag straight from registers
   always_comb busy = (|pending_q) | enable;

endmodule
